nibble_serial_sub16: RTL and testbench

- Multi-cycle subtractor; the inverse operation of the 16-bit carry-lookahead adder.
- Computes diff = a - b - bin one 4-bit nibble per clock, LSB nibble first, with a rippled borrow.
- Operand and result sides use valid/ready handshakes, so it drops into the sequential ALU datapath.
- Trades area for latency: one 4-bit subtract slice is reused across WIDTH/NIB cycles.

---
 rtl/nibble_serial_sub16_pkg.sv | 29 ++
 rtl/nibble_serial_sub16_if.sv | 41 ++++
 rtl/nibble_serial_sub16_nib_sub4.sv | 58 +++++
 rtl/nibble_serial_sub16.sv | 193 +++++++++++++++++++
 tb/tb_nibble_serial_sub16.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_sub16_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the nibble-serial subtractor:
//   state_e      - controller states IDLE / BUSY / DONE
//   DEF_WIDTH    - default operand/result width
//   DEF_NIB      - default bits processed per clock
//   DEF_NSTEPS   - default number of nibble steps per operation
//   DEF_CNT_W    - default nibble counter width
//   cnt_width()  - counter width for an arbitrary step count (minimum 1 bit)
// -----------------------------------------------------------------------------
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NIB    = 4;
    localparam int DEF_NSTEPS = DEF_WIDTH / DEF_NIB;
    localparam int DEF_CNT_W  = (DEF_NSTEPS > 1) ? $clog2(DEF_NSTEPS) : 1;

    // A single-step configuration still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int nsteps);
        return (nsteps > 1) ? $clog2(nsteps) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_sub16_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub16_if
// Operand and result handshake bundle for the nibble-serial subtractor.
//   Operand side : in_valid, in_ready, a, b, bin
//   Result side  : out_valid, out_ready, diff, bout, zero, neg, ovf
// Modports:
//   master - the producer/consumer around the subtractor (drives operands and
//            out_ready, observes results)
//   slave  - the subtractor itself
// -----------------------------------------------------------------------------
interface nibble_serial_sub16_if
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, neg, ovf
    );

endinterface

// File: rtl/nibble_serial_sub16_nib_sub4.sv
// -----------------------------------------------------------------------------
// nib_sub4
// Combinational NIB-bit subtract slice: {bout_o, d_o} = x - y - bin_i.
// Implemented as x + ~y + ~bin_i with carry lookahead; borrow is the inverted
// carry out of the top bit.
// Ports:
//   x      in  NIB  minuend nibble
//   y      in  NIB  subtrahend nibble
//   bin_i  in  1    borrow in
//   d_o    out NIB  difference nibble
//   bout_o out 1    borrow out
// -----------------------------------------------------------------------------
module nib_sub4
    import sub_pkg::*;
#(
    parameter int NIB = DEF_NIB
) (
    input  logic [NIB-1:0] x,
    input  logic [NIB-1:0] y,
    input  logic           bin_i,
    output logic [NIB-1:0] d_o,
    output logic           bout_o
);

    logic [NIB-1:0] g;
    logic [NIB-1:0] p;
    logic [NIB:0]   c;
    logic           pp;

    // Each carry is the flat sum-of-products form
    //   c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c[0]
    // so no carry depends on another carry inside the slice.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves it unassigned and no latch is inferred.
        g  = x & ~y;
        p  = x ^ ~y;
        c  = '0;
        pp = 1'b1;
        c[0] = ~bin_i;
        for (int i = 0; i < NIB; i++) begin
            c[i+1] = g[i];
            pp     = 1'b1;
            for (int j = i; j >= 0; j--) begin
                pp = pp & p[j];
                if (j > 0) begin
                    c[i+1] = c[i+1] | (g[j-1] & pp);
                end else begin
                    c[i+1] = c[i+1] | (c[0] & pp);
                end
            end
        end
    end

    assign d_o    = p ^ c[NIB-1:0];
    assign bout_o = ~c[NIB];

endmodule

// File: rtl/nibble_serial_sub16.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub16
// Multi-cycle subtractor: diff = a - b - bin, one NIB-bit slice per clock,
// least significant nibble first, with the borrow rippled through a register.
// A single nib_sub4 slice is reused for all WIDTH/NIB steps.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of nibble_serial_sub16_if
//          operands : in_valid / in_ready, a, b, bin
//          results  : out_valid / out_ready, diff, bout, zero, neg, ovf
//
// Timing: out_valid rises WIDTH/NIB edges after the accepting edge and stays
// up until out_ready is seen; a new operand is accepted at most every
// WIDTH/NIB + 2 cycles. All outputs come straight from flops.
//
// Build option: define SUB_FLAGS_EN to compute and register zero/neg/ovf on
// the transition to DONE. Without it those outputs are tied to 0.
// -----------------------------------------------------------------------------
module nibble_serial_sub16
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NIB   = DEF_NIB
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_sub16_if.slave bus
);

    localparam int NSTEPS = WIDTH / NIB;
    localparam int CNT_W  = cnt_width(NSTEPS);
    localparam int MSB    = WIDTH - 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

    // Plain 2-bit encodings of the shared state enum.
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;

    logic [NIB-1:0]   a_nib;
    logic [NIB-1:0]   b_nib;
    logic [NIB-1:0]   nib_diff;
    logic             nib_bout;
    logic             last_step;

    assign a_nib     = a_q[int'(cnt_q)*NIB +: NIB];
    assign b_nib     = b_q[int'(cnt_q)*NIB +: NIB];
    assign last_step = (cnt_q == LAST_CNT);

    nib_sub4 #(
        .NIB (NIB)
    ) u_slice (
        .x      (a_nib),
        .y      (b_nib),
        .bin_i  (borrow_q),
        .d_o    (nib_diff),
        .bout_o (nib_bout)
    );

    // -------------------------------------------------------------------------
    // Controller and datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end

            S_BUSY: begin
                diff_d[int'(cnt_q)*NIB +: NIB] = nib_diff;
                borrow_d = nib_bout;
                if (last_step) begin
                    bout_d  = nib_bout;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: operand and result registers are ordinary flops, so they
            // are reset alongside the controller; there is no memory array here
            // that would need to be left unreset.
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Result flags
    // -------------------------------------------------------------------------
`ifdef SUB_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q,  neg_d;
    logic ovf_q,  ovf_d;

    // Flags are taken from diff_d so they describe the completed result on the
    // same edge that enters DONE. bin affects ovf only through diff.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (state_q == S_BUSY && last_step) begin
            zero_d = (diff_d == '0);
            neg_d  = diff_d[MSB];
            ovf_d  = (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
`else
    assign bus.zero = 1'b0;
    assign bus.neg  = 1'b0;
    assign bus.ovf  = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs: decoded from state flops, never from inputs
    // -------------------------------------------------------------------------
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_sub16
// Directed bench for nibble_serial_sub16. Inputs are driven and outputs are
// sampled 1 time unit after each rising edge. Flag expectations follow the
// SUB_FLAGS_EN build option (tied to 0 when it is undefined).
// -----------------------------------------------------------------------------
module tb_nibble_serial_sub16;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    nibble_serial_sub16_if #(.WIDTH(16)) bus ();

    nibble_serial_sub16 #(
        .WIDTH (16),
        .NIB   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic fx(input logic v);
`ifdef SUB_FLAGS_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set, then waits (bounded) for out_valid.
    // lat counts edges after the accepting edge; -1 means no result appeared.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output int lat, output logic [15:0] d, output logic bo,
                         output logic z, output logic n, output logic o);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            tick();
            guard++;
        end
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        d  = bus.diff;
        bo = bus.bout;
        z  = bus.zero;
        n  = bus.neg;
        o  = bus.ovf;
    endtask

    task automatic test_reset;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.diff !== 16'h0000) begin errors++; $display("FAIL rst_diff got %h exp 0000", bus.diff); end
        checks++; if ({bus.bout, bus.zero, bus.neg, bus.ovf} !== 4'b0000) begin errors++;
            $display("FAIL rst_flags got %b exp 0000", {bus.bout, bus.zero, bus.neg, bus.ovf}); end
    endtask

    task automatic test_basic;
        int lat; logic [15:0] d; logic bo, z, n, o;
        bus.out_ready = 1'b1;
        do_op(16'h1234, 16'h0234, 1'b0, lat, d, bo, z, n, o);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
        checks++; if (d !== 16'h1000) begin errors++; $display("FAIL basic_diff got %h exp 1000", d); end
        checks++; if ({bo, z, n, o} !== 4'b0000) begin errors++; $display("FAIL basic_flags got %b exp 0000", {bo, z, n, o}); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_exclusive got in_ready %b exp 0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_underflow;
        int lat; logic [15:0] d; logic bo, z, n, o;
        bus.out_ready = 1'b1;
        do_op(16'h0000, 16'h0001, 1'b0, lat, d, bo, z, n, o);
        checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL uflow_diff got %h exp ffff", d); end
        checks++; if ({bo, z, n, o} !== {1'b1, 1'b0, fx(1'b1), 1'b0}) begin errors++;
            $display("FAIL uflow_flags got %b exp %b", {bo, z, n, o}, {1'b1, 1'b0, fx(1'b1), 1'b0}); end
        tick();
        do_op(16'h0000, 16'h0001, 1'b1, lat, d, bo, z, n, o);
        checks++; if (d !== 16'hFFFE) begin errors++; $display("FAIL uflow_bin_diff got %h exp fffe", d); end
        checks++; if ({bo, n} !== {1'b1, fx(1'b1)}) begin errors++;
            $display("FAIL uflow_bin_flags got %b exp %b", {bo, n}, {1'b1, fx(1'b1)}); end
        tick();
    endtask

    task automatic test_overflow;
        int lat; logic [15:0] d; logic bo, z, n, o;
        bus.out_ready = 1'b1;
        do_op(16'h8000, 16'h0001, 1'b0, lat, d, bo, z, n, o);
        checks++; if (d !== 16'h7FFF) begin errors++; $display("FAIL ovf_diff got %h exp 7fff", d); end
        checks++; if ({bo, z, n, o} !== {1'b0, 1'b0, 1'b0, fx(1'b1)}) begin errors++;
            $display("FAIL ovf_flags got %b exp %b", {bo, z, n, o}, {1'b0, 1'b0, 1'b0, fx(1'b1)}); end
        tick();
        do_op(16'h5A5A, 16'h5A5A, 1'b0, lat, d, bo, z, n, o);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL equal_diff got %h exp 0000", d); end
        checks++; if ({bo, z, n, o} !== {1'b0, fx(1'b1), 1'b0, 1'b0}) begin errors++;
            $display("FAIL equal_flags got %b exp %b", {bo, z, n, o}, {1'b0, fx(1'b1), 1'b0, 1'b0}); end
        tick();
    endtask

    task automatic test_backpressure;
        int lat; logic [15:0] d; logic bo, z, n, o;
        bus.out_ready = 1'b0;
        do_op(16'h1111, 16'h0001, 1'b0, lat, d, bo, z, n, o);
        checks++; if (d !== 16'h1110) begin errors++; $display("FAIL bp_diff got %h exp 1110", d); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a        = 16'hAAAA;
            bus.b        = 16'h5555;
            tick();
            checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin errors++;
                $display("FAIL bp_hs[%0d] got %b exp 10", i, {bus.out_valid, bus.in_ready}); end
            checks++; if ({bus.diff, bus.bout, bus.zero, bus.neg, bus.ovf} !== {16'h1110, 4'b0000}) begin errors++;
                $display("FAIL bp_hold[%0d] got %h/%b exp 1110/0000", i, bus.diff, {bus.bout, bus.zero, bus.neg, bus.ovf}); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++;
            $display("FAIL bp_release got %b exp 01", {bus.out_valid, bus.in_ready}); end
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_not_queued got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_op;
        int lat; logic [15:0] d; logic bo, z, n, o;
        bus.out_ready = 1'b1;
        bus.a         = 16'hFFFF;
        bus.b         = 16'h0001;
        bus.bin       = 1'b0;
        bus.in_valid  = 1'b1;
        tick();                 // accept
        bus.in_valid = 1'b0;
        tick();                 // now in the 2nd BUSY cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin errors++;
            $display("FAIL midrst_hs got %b exp 10", {bus.in_ready, bus.out_valid}); end
        checks++; if ({bus.diff, bus.bout} !== 17'h0) begin errors++;
            $display("FAIL midrst_diff got %h/%b exp 0000/0", bus.diff, bus.bout); end
        do_op(16'h0010, 16'h0001, 1'b0, lat, d, bo, z, n, o);
        checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got %0d exp 4", lat); end
        checks++; if ({d, bo} !== {16'h000F, 1'b0}) begin errors++;
            $display("FAIL midrst_result got %h/%b exp 000f/0", d, bo); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [15:0] av [3] = '{16'h0005, 16'hFFFF, 16'h0100};
        logic [15:0] bv [3] = '{16'h0005, 16'hFFFF, 16'h00FF};
        logic        cv [3] = '{1'b1, 1'b0, 1'b0};
        logic [15:0] ed [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        logic        eb [3] = '{1'b1, 1'b0, 1'b0};
        logic        ez [3] = '{1'b0, 1'b1, 1'b0};
        logic        en [3] = '{1'b1, 1'b0, 1'b0};
        int acc_cyc [3] = '{0, 0, 0};
        int n_acc = 0, n_res = 0, cyc = 0;
        logic pre;
        bus.out_ready = 1'b1;
        bus.a   = av[0];
        bus.b   = bv[0];
        bus.bin = cv[0];
        bus.in_valid = 1'b1;
        while (n_res < 3 && cyc < 60) begin
            pre = bus.in_ready && bus.in_valid;
            tick();
            cyc++;
            if (pre && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 3) begin
                    bus.a   = av[n_acc];
                    bus.b   = bv[n_acc];
                    bus.bin = cv[n_acc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            checks++; if (bus.in_ready && bus.out_valid) begin errors++;
                $display("FAIL b2b_exclusive cyc %0d got 11 exp not both", cyc); end
            if (bus.out_valid) begin
                checks++; if ({bus.diff, bus.bout} !== {ed[n_res], eb[n_res]}) begin errors++;
                    $display("FAIL b2b_result[%0d] got %h/%b exp %h/%b", n_res, bus.diff, bus.bout, ed[n_res], eb[n_res]); end
                checks++; if ({bus.zero, bus.neg, bus.ovf} !== {fx(ez[n_res]), fx(en[n_res]), 1'b0}) begin errors++;
                    $display("FAIL b2b_flags[%0d] got %b exp %b", n_res, {bus.zero, bus.neg, bus.ovf},
                             {fx(ez[n_res]), fx(en[n_res]), 1'b0}); end
                n_res++;
            end
        end
        checks++; if (n_res !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n_res); end
        checks++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin errors++;
            $display("FAIL b2b_spacing01 got %0d exp 6", acc_cyc[1] - acc_cyc[0]); end
        checks++; if (acc_cyc[2] - acc_cyc[1] !== 6) begin errors++;
            $display("FAIL b2b_spacing12 got %0d exp 6", acc_cyc[2] - acc_cyc[1]); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
